// File: rtl/la_dpram.sv
// Dual-port RAM with one masked write port and one registered read port.
// Latency: 1 cycle from rd_en to rd_dout. rd_dout holds its value while rd_en is low.
// Backpressure: none. The caller must never read and write the same address on one edge.
module la_dpram #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter     TYPE  = "DEFAULT",
  parameter int CTRLW = 128,
  parameter int TESTW = 128
) (
  input  logic             wr_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_din,
  input  logic [DW-1:0]    wr_mask,
  input  logic             rd_clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_dout,
  input  logic             vss,
  input  logic             vdd,
  input  logic             vddio,
  input  logic [CTRLW-1:0] ctrl,
  input  logic [TESTW-1:0] test
);

  logic [DW-1:0] mem [2**AW];

  // Macro-select, power and test pins only matter to hard macros, not to this model.
  logic unused_pins;
  assign unused_pins = ^{vss, vdd, vddio, ctrl, test, (TYPE == "DEFAULT")};

  // Bit-masked write
  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_din & wr_mask);
  end

  // Registered read; output holds between reads
  always_ff @(posedge rd_clk) begin
    if (rd_en) rd_dout <= mem[rd_addr];
  end

endmodule

// File: rtl/la_dpram_fifo.sv
// Synchronous FIFO: 2**AW-word dual-port RAM plus a 2-entry output buffer (capacity 2**AW+2).
// Latency: a push into an empty block shows on out_valid two edges later; one push and one pop per cycle sustained.
// Backpressure: in_ready = !full (RAM full only), independent of out_ready; out_data holds while stalled.
module la_dpram_fifo #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter     TYPE  = "DEFAULT",
  parameter int CTRLW = 128,
  parameter int TESTW = 128,
  localparam int CNTW = AW + 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty,
  input  logic             vss,
  input  logic             vdd,
  input  logic             vddio,
  input  logic [CTRLW-1:0] ctrl,
  input  logic [TESTW-1:0] test
);

  localparam int CAP = (2**AW) + 2;

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          pend_q, pend_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   ram_words;
  logic [2:0]    occ;
  logic          push, pop, rd_issue, ram_empty;

  assign ram_words = wr_ptr_q - rd_ptr_q;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop       = out_valid & out_ready;

  // Slots the buffer will need after this edge: held words plus the in-flight read, minus a pop.
  // Keeping this below 2 also guarantees a pending read always has a slot to land in.
  assign occ      = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_issue = ~ram_empty & (occ < 3'd2);

  assign count = {1'b0, ram_words} + {{(CNTW-1){1'b0}}, pend_q} + {{(CNTW-2){1'b0}}, buf_cnt_q};
  assign empty = (count == '0);

  la_dpram #(
    .DW(DW), .AW(AW), .TYPE(TYPE), .CTRLW(CTRLW), .TESTW(TESTW)
  ) u_ram (
    .wr_clk (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_din (in_data),
    .wr_mask({DW{1'b1}}),
    .rd_clk (clk),
    .rd_en  (rd_issue),
    .rd_addr(rd_ptr_q[AW-1:0]),
    .rd_dout(ram_dout),
    .vss    (vss),
    .vdd    (vdd),
    .vddio  (vddio),
    .ctrl   (ctrl),
    .test   (test)
  );

  // Next state: pointer advance, read pipeline, buffer shift on pop then fill from RAM
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_issue};
    pend_d    = rd_issue;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (pend_q) begin
      if (buf_cnt_d == 2'd0) buf0_d = ram_dout;
      else                   buf1_d = ram_dout;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  // State registers; RAM contents deliberately left out of reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_q    <= pend_d;
      buf_cnt_q <= buf_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

  // Occupancy can never exceed RAM depth plus the two buffer slots
  assert property (@(posedge clk) disable iff (!nreset) count <= CNTW'(CAP));

endmodule

// File: tb/tb_la_dpram_fifo.sv
// Self-checking bench for la_dpram_fifo with DW=8, AW=2 (capacity 6).
// Reference model: a queue of (data, push edge); a word is visible two edges after its push.
// Inputs driven on the falling edge, outputs checked on the falling edge.
module tb_la_dpram_fifo;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int CAP = 6;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [AW+1:0] count;
  logic          full;
  logic          empty;
  logic [127:0]  ctrl = '0;
  logic [127:0]  test = '0;

  always #5 clk = ~clk;

  la_dpram_fifo #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .vss(1'b0), .vdd(1'b1), .vddio(1'b1),
    .ctrl(ctrl), .test(test)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t q[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic exp_valid();
    return (q.size() > 0) && (q[0].t + 2 <= edge_n);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid()));
    if (exp_valid()) chk({tag, " out_data"}, 32'(out_data), 32'(q[0].d));
    if (q.size() == CAP)          chk({tag, " in_ready@cap"}, 32'(in_ready), 32'd0);
    else if (q.size() <= CAP - 2) chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One clock: drive, let the model decide the handshake, advance, check
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy);
    logic do_push, do_pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    do_pop    = exp_valid() && ordy;
    if (q.size() == CAP)          do_push = 1'b0;
    else if (q.size() <= CAP - 2) do_push = iv;
    else                          do_push = iv && in_ready;
    @(posedge clk);
    edge_n++;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{id, edge_n});
    @(negedge clk);
    check_state("cyc");
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) cycle(1'b0, '0, 1'b1);
    chk("drain empty", 32'(empty), 32'd1);
  endtask

  task automatic pop_one(output logic [DW-1:0] v);
    v = '0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        v = out_data;
        cycle(1'b0, '0, 1'b1);
        return;
      end
      cycle(1'b0, '0, 1'b0);
    end
    chk("pop timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int            pops;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    nreset = 1'b1;

    // Latency into an empty block
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("lat early", 32'(out_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk("lat valid", 32'(out_valid), 32'd1);
    chk("lat data", 32'(out_data), 32'h11);
    chk("lat count", 32'(count), 32'd1);
    drain();

    // Fill to capacity, reject overflow, hold, then drain in order
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("fill in_ready", 32'(in_ready), 32'd0);
    chk("fill full", 32'(full), 32'd1);
    chk("fill count", 32'(count), 32'd6);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("ovf count", 32'(count), 32'd6);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0);
      chk("hold data", 32'(out_data), 32'h01);
      chk("hold valid", 32'(out_valid), 32'd1);
    end
    for (int i = 1; i <= 6; i++) begin
      pop_one(v);
      chk("order", 32'(v), 32'(i));
    end
    chk("order empty", 32'(empty), 32'd1);

    // Pop from a full block while offering 0x77; it is taken once space opens
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h21 + 8'(i), 1'b0);
    chk("full2 count", 32'(count), 32'd6);
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b1, 8'h77, 1'b0);
    chk("pp count", 32'(count), 32'd6);
    for (int i = 0; i < 5; i++) begin
      pop_one(v);
      chk("pp order", 32'(v), 32'(8'h22 + 8'(i)));
    end
    pop_one(v);
    chk("pp last", 32'(v), 32'h77);
    chk("pp empty", 32'(empty), 32'd1);

    // Streaming: push and pop every cycle across several wraps
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) pops++;
      cycle(1'b1, 8'h40 + 8'(i), 1'b1);
    end
    chk("stream pops", 32'(pops), 32'd17);
    chk("stream count", 32'(count), 32'd3);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();

    // Reset mid-stream
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("pre-rst count", 32'(count), 32'd4);
    nreset = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst out_data", 32'(out_data), 32'd0);
    chk("mid-rst count", 32'(count), 32'd0);
    chk("mid-rst empty", 32'(empty), 32'd1);
    chk("mid-rst full", 32'(full), 32'd0);
    chk("mid-rst in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    nreset = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("post-rst valid", 32'(out_valid), 32'd1);
    chk("post-rst data", 32'(out_data), 32'h5A);
    chk("post-rst count", 32'(count), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
